ac_level_vlc_encoder: RTL

//  Parametrised, handshaked successor of the AC level coefficient encoder. Takes one signed AC

---
 rtl/ac_vlc_pkg.sv | 26 ++
 rtl/exp_golomb_len_enc.sv | 38 +++
 rtl/ac_level_vlc_encoder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ac_vlc_pkg.sv
// Shared types and helpers for the AC level VLC encoder.
// Optional build macro: AC_LEVEL_STATS_EN (see ac_level_vlc_encoder).
package ac_vlc_pkg;

  // History is saturated at this value; all larger levels share one codebook.
  localparam int unsigned MAX_PREV = 8;

  // T = switch threshold into the Exp-Golomb tail, k = Exp-Golomb order.
  typedef struct packed {
    logic [1:0] T;
    logic [1:0] k;
  } codebook_t;

  // Adaptive codebook selection from the previous nonzero |level|-1.
  function automatic codebook_t lvl_to_codebook(input logic [3:0] prev);
    codebook_t cb;
    if (prev == 4'd0)                cb = '{T: 2'd3, k: 2'd2};
    else if (prev == 4'd1)           cb = '{T: 2'd2, k: 2'd1};
    else if (prev == 4'd2)           cb = '{T: 2'd3, k: 2'd1};
    else if (prev == 4'd3)           cb = '{T: 2'd0, k: 2'd0};
    else if (prev < 4'(MAX_PREV))    cb = '{T: 2'd0, k: 2'd1};
    else                             cb = '{T: 2'd0, k: 2'd2};
    return cb;
  endfunction

endpackage

// File: rtl/exp_golomb_len_enc.sv
// Combinational magnitude coder: unary prefix below threshold T, otherwise
// T zeros followed by an order-k Exp-Golomb code of (v-T). Leading zeros are
// implicit in the right-aligned code; only the length accounts for them.
module exp_golomb_len_enc #(
  parameter int V_W  = 19,
  parameter int CW_W = 48,
  localparam int LEN_W = $clog2(CW_W + 1),
  localparam int C_W   = CW_W - 1
) (
  input  logic [V_W-1:0]   v_i,
  input  logic [1:0]       t_i,
  input  logic [1:0]       k_i,
  output logic [C_W-1:0]   code_o,
  output logic [LEN_W-1:0] len_o
);

  localparam int M_W = V_W + 1;

  logic [M_W-1:0]   m;
  logic [LEN_W-1:0] n;

  // Build m = (v-T)+2^k, find its MSB position, then select unary or EG form.
  always_comb begin
    m = M_W'(v_i) - M_W'(t_i) + (M_W'(1) << k_i);
    n = '0;
    for (int i = 0; i < M_W; i++) begin
      if (m[i]) n = LEN_W'(i);
    end
    if (v_i < V_W'(t_i)) begin
      code_o = C_W'(1);
      len_o  = LEN_W'(v_i) + LEN_W'(1);
    end else begin
      code_o = C_W'(m);
      len_o  = LEN_W'(t_i) + (n << 1) - LEN_W'(k_i) + LEN_W'(1);
    end
  end

endmodule

// File: rtl/ac_level_vlc_encoder.sv
// AC level VLC encoder: drops zero levels, picks an adaptive codebook from
// the previous nonzero level, emits LSB-aligned codeword + length.
// Two-stage pipeline with valid/ready backpressure on both sides.
// Optional build macro: AC_LEVEL_STATS_EN adds stat_coeffs / stat_bits.
module ac_level_vlc_encoder
  import ac_vlc_pkg::*;
#(
  parameter int COEFF_W = 20,
  parameter int CW_W    = 48,
  localparam int LEN_W  = $clog2(CW_W + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_level,
  input  logic                      in_first,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW_W-1:0]           out_codeword,
  output logic [LEN_W-1:0]          out_len
`ifdef AC_LEVEL_STATS_EN
  ,
  output logic [31:0]               stat_coeffs,
  output logic [31:0]               stat_bits
`endif
);

  localparam int V_W = COEFF_W - 1;

  logic               accept_p0;
  logic               sgn_p0;
  logic               nz_p0;
  logic [COEFF_W-1:0] mag_p0;
  logic [V_W-1:0]     v_p0;
  logic [3:0]         p_p0;
  codebook_t          cb_p0;

  logic [3:0]         prev_lvl_q, prev_lvl_d;
  logic               first_pend_q, first_pend_d;

  logic               vld_p1_q;
  logic [V_W-1:0]     v_p1_q;
  logic               sgn_p1_q;
  codebook_t          cb_p1_q;
  logic               ld_p2;

  logic               vld_p2_q;
  logic [CW_W-1:0]    cw_p2_q;
  logic [LEN_W-1:0]   len_p2_q;

  logic [CW_W-2:0]    mag_code;
  logic [LEN_W-1:0]   mag_len;

  assign ld_p2     = !vld_p2_q || out_ready;
  assign in_ready  = !vld_p1_q || ld_p2;
  assign accept_p0 = in_valid && in_ready;

  // Stage 0: magnitude, sign, codebook choice and history next-state.
  always_comb begin
    sgn_p0       = in_level[COEFF_W-1];
    nz_p0        = |in_level;
    mag_p0       = sgn_p0 ? $unsigned(-in_level) : $unsigned(in_level);
    v_p0         = V_W'(mag_p0 - COEFF_W'(1));
    p_p0         = (in_first || first_pend_q) ? 4'd1 : prev_lvl_q;
    cb_p0        = lvl_to_codebook(p_p0);
    prev_lvl_d   = prev_lvl_q;
    first_pend_d = first_pend_q;
    if (accept_p0) begin
      if (nz_p0) begin
        prev_lvl_d   = (v_p0 >= V_W'(MAX_PREV)) ? 4'(MAX_PREV) : v_p0[3:0];
        first_pend_d = 1'b0;
      end else if (in_first) begin
        first_pend_d = 1'b1;
      end
    end
  end

  // Control, history and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_lvl_q   <= 4'd1;
      first_pend_q <= 1'b1;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      cw_p2_q      <= '0;
      len_p2_q     <= '0;
    end else begin
      prev_lvl_q   <= prev_lvl_d;
      first_pend_q <= first_pend_d;
      if (in_ready) vld_p1_q <= accept_p0 && nz_p0;
      if (ld_p2) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          cw_p2_q  <= {mag_code, sgn_p1_q};
          len_p2_q <= mag_len + LEN_W'(1);
        end
      end
    end
  end

  // Stage 1 data: captured on every accepted beat, qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      v_p1_q   <= v_p0;
      sgn_p1_q <= sgn_p0;
      cb_p1_q  <= cb_p0;
    end
  end

  // Stage 2: magnitude code build feeding the output register.
  exp_golomb_len_enc #(
    .V_W  (V_W),
    .CW_W (CW_W)
  ) u_eg (
    .v_i    (v_p1_q),
    .t_i    (cb_p1_q.T),
    .k_i    (cb_p1_q.k),
    .code_o (mag_code),
    .len_o  (mag_len)
  );

  assign out_valid    = vld_p2_q;
  assign out_codeword = cw_p2_q;
  assign out_len      = len_p2_q;

`ifdef AC_LEVEL_STATS_EN
  // Per-block statistics; a new block restarts counting before its first codeword.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_coeffs <= '0;
      stat_bits   <= '0;
    end else if (accept_p0 && in_first) begin
      stat_coeffs <= '0;
      stat_bits   <= '0;
    end else if (out_valid && out_ready) begin
      stat_coeffs <= stat_coeffs + 32'd1;
      stat_bits   <= stat_bits + 32'(out_len);
    end
  end
`endif

endmodule
